// File: rtl/bip_pkg.sv
// bip_pkg: shared constants for the accumulator CPU.
//   - datapath / program memory widths
//   - opcode encodings seen by the decoder
//   - fetch sequencer state encoding (fixed values, visible on debug taps)
package bip_pkg;

    localparam int PC_BITS    = 11;
    localparam int INSTR_BITS = 16;
    localparam int OPCODE     = 5;
    localparam int OPERAND    = 11;

    localparam logic [OPCODE-1:0] HLT  = 5'd0;
    localparam logic [OPCODE-1:0] STO  = 5'd1;
    localparam logic [OPCODE-1:0] LD   = 5'd2;
    localparam logic [OPCODE-1:0] LDI  = 5'd3;
    localparam logic [OPCODE-1:0] ADD  = 5'd4;
    localparam logic [OPCODE-1:0] ADDI = 5'd5;
    localparam logic [OPCODE-1:0] SUB  = 5'd6;
    localparam logic [OPCODE-1:0] SUBI = 5'd7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        EXEC  = 3'd3,
        PAUSE = 3'd4,
        HALT  = 3'd5
    } fetchState_t;

endpackage

// File: rtl/program_counter.sv
// program_counter: PC register with synchronous clear, increment and hold.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (PC -> 0)
//   clr        : load zero (takes priority over inc)
//   inc        : advance by one, wrapping modulo 2^WIDTH
//   pc         : current program counter
module program_counter
    import bip_pkg::*;
#(
    parameter int WIDTH = PC_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] pc
);

    // Natural binary overflow gives the 0x7FF -> 0x000 wrap for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   pc <= '0;
        else if (clr) pc <= '0;
        else if (inc) pc <= pc + 1'b1;
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch/sequencing stage in front of the decoder.
// Owns the PC, reads synchronous program memory, registers opcode/operand
// and presents one execute slot per instruction.
// Ports:
//   i_Clk, i_Rst_n      : clock, asynchronous active-low reset
//   i_Start             : run request (clears PC), honoured in IDLE/PAUSE/HALT
//   i_StepMode, i_Step  : pause after each instruction / resume from pause
//   o_PmEn, o_PmAddr    : program memory read strobe and address (= PC)
//   i_PmData            : instruction, valid the cycle after o_PmEn
//   o_Opcode, o_Operand : registered instruction fields
//   o_InstrValid        : execute slot strobe
//   i_WrPC              : decoder advance control, looked at only in EXEC
//   o_PC, o_Busy, o_Halted : status for the debug front end
module instruction_fetch
    import bip_pkg::*;
#(
    parameter int PC_W    = PC_BITS,
    parameter int INSTR_W = INSTR_BITS,
    parameter int OPC_W   = OPCODE,
    parameter int OPR_W   = OPERAND
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Start,
    input  logic               i_StepMode,
    input  logic               i_Step,
    output logic               o_PmEn,
    output logic [PC_W-1:0]    o_PmAddr,
    input  logic [INSTR_W-1:0] i_PmData,
    output logic [OPC_W-1:0]   o_Opcode,
    output logic [OPR_W-1:0]   o_Operand,
    output logic               o_InstrValid,
    input  logic               i_WrPC,
    output logic [PC_W-1:0]    o_PC,
    output logic               o_Busy,
    output logic               o_Halted
);

    fetchState_t state, stateNext;
    logic        pcClr, pcInc;
    logic [PC_W-1:0] pc;

    program_counter #(.WIDTH(PC_W)) uPc (
        .clk   (i_Clk),
        .rst_n (i_Rst_n),
        .clr   (pcClr),
        .inc   (pcInc),
        .pc    (pc)
    );

    always_comb begin
        stateNext = state;
        pcClr     = 1'b0;
        pcInc     = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (i_Start) begin
                    pcClr     = 1'b1;
                    stateNext = FETCH;
                end
            end
            FETCH: stateNext = WAIT;
            WAIT:  stateNext = EXEC;
            EXEC: begin
                // A decoder that refuses to advance (HLT / undefined) stops us.
                if (i_WrPC) begin
                    pcInc     = 1'b1;
                    stateNext = i_StepMode ? PAUSE : FETCH;
                end else begin
                    stateNext = HALT;
                end
            end
            PAUSE: begin
                if (i_Start) begin
                    pcClr     = 1'b1;
                    stateNext = FETCH;
                end else if (i_Step) begin
                    stateNext = FETCH;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) state <= IDLE;
        else          state <= stateNext;
    end

    // Instruction register: loaded once per instruction, held otherwise.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Opcode  <= '0;
            o_Operand <= '0;
        end else if (state == WAIT) begin
            o_Opcode  <= i_PmData[INSTR_W-1 -: OPC_W];
            o_Operand <= i_PmData[OPR_W-1:0];
        end
    end

    // Strobes decode from the state register only, so reset kills them at once.
    assign o_PmEn       = (state == FETCH);
    assign o_PmAddr     = pc;
    assign o_PC         = pc;
    assign o_InstrValid = (state == EXEC);
    assign o_Busy       = (state == FETCH) || (state == WAIT) || (state == EXEC);
    assign o_Halted     = (state == HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: program memory model, small decoder model,
// scoreboard of expected execute slots (opcode, operand, PC, slot timing).
module tb_instruction_fetch;
    import bip_pkg::*;

    logic        i_Clk = 1'b0;
    logic        i_Rst_n, i_Start, i_StepMode, i_Step;
    logic        o_PmEn, o_InstrValid, o_Busy, o_Halted;
    logic [10:0] o_PmAddr, o_Operand, o_PC;
    logic [15:0] i_PmData = '0;
    logic [4:0]  o_Opcode;
    logic        i_WrPC;

    instruction_fetch dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Start(i_Start),
        .i_StepMode(i_StepMode), .i_Step(i_Step),
        .o_PmEn(o_PmEn), .o_PmAddr(o_PmAddr), .i_PmData(i_PmData),
        .o_Opcode(o_Opcode), .o_Operand(o_Operand), .o_InstrValid(o_InstrValid),
        .i_WrPC(i_WrPC), .o_PC(o_PC), .o_Busy(o_Busy), .o_Halted(o_Halted)
    );

    always #5 i_Clk = ~i_Clk;

    logic [15:0] mem [0:2047];
    always @(posedge i_Clk) if (o_PmEn) i_PmData <= mem[o_PmAddr];

    // Decoder model: defined non-HLT opcodes advance the PC.
    assign i_WrPC = o_InstrValid && (o_Opcode != HLT) && (o_Opcode <= SUBI);

    typedef struct {
        logic [4:0]  op;
        logic [10:0] opr;
        logic [10:0] pc;
        int          dly;
    } exp_t;

    exp_t sb[$];
    int   total = 0, bad = 0;
    int   cyc = 0, kickCyc = 0, nValid = 0;

    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every execute slot must match the oldest expectation.
    always @(negedge i_Clk) begin
        if (i_Rst_n === 1'b1 && o_InstrValid === 1'b1) begin
            exp_t e;
            nValid++;
            if (sb.size() == 0) begin
                chk("extraSlot", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("opcode", 32'(o_Opcode), 32'(e.op));
                chk("operand", 32'(o_Operand), 32'(e.opr));
                chk("slotPc", 32'(o_PC), 32'(e.pc));
                chk("slotTime", 32'(cyc - kickCyc), 32'(e.dly));
            end
        end
    end

    function automatic exp_t mk(logic [4:0] op, logic [10:0] opr, logic [10:0] pc, int dly);
        exp_t e;
        e.op = op; e.opr = opr; e.pc = pc; e.dly = dly;
        return e;
    endfunction

    task automatic loadProg();
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        mem[0] = {LDI, 11'd5};
        mem[1] = {ADDI, 11'd3};
        mem[2] = {STO, 11'd10};
        mem[3] = {HLT, 11'd0};
    endtask

    task automatic pushProg();
        sb.push_back(mk(LDI, 11'd5, 11'd0, 3));
        sb.push_back(mk(ADDI, 11'd3, 11'd1, 6));
        sb.push_back(mk(STO, 11'd10, 11'd2, 9));
        sb.push_back(mk(HLT, 11'd0, 11'd3, 12));
    endtask

    // Returns on the negedge one cycle after the start pulse (FETCH expected).
    task automatic startRun();
        @(negedge i_Clk);
        kickCyc = cyc;
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
    endtask

    task automatic stepPulse();
        @(negedge i_Clk);
        kickCyc = cyc;
        i_Step = 1'b1;
        @(negedge i_Clk);
        i_Step = 1'b0;
    endtask

    task automatic waitHalt(input int budget);
        int n = 0;
        while (o_Halted !== 1'b1 && n < budget) begin
            @(negedge i_Clk);
            n++;
        end
        if (o_Halted !== 1'b1) chk("haltTimeout", 32'd0, 32'd1);
    endtask

    task automatic waitValid(input int target, input int budget);
        int n = 0;
        while (nValid < target && n < budget) begin
            @(negedge i_Clk);
            n++;
        end
        if (nValid < target) chk("validTimeout", 32'(nValid), 32'(target));
    endtask

    initial begin
        int base, busyCnt;
        i_Rst_n = 1'b0; i_Start = 1'b0; i_StepMode = 1'b0; i_Step = 1'b0;
        loadProg();
        repeat (3) @(negedge i_Clk);
        chk("rstPc", 32'(o_PC), 0);
        chk("rstPmAddr", 32'(o_PmAddr), 0);
        chk("rstPmEn", 32'(o_PmEn), 0);
        chk("rstOpcode", 32'(o_Opcode), 0);
        chk("rstOperand", 32'(o_Operand), 0);
        chk("rstValid", 32'(o_InstrValid), 0);
        chk("rstBusy", 32'(o_Busy), 0);
        chk("rstHalted", 32'(o_Halted), 0);
        i_Rst_n = 1'b1;
        repeat (2) @(negedge i_Clk);

        // Run mode; a start during WAIT and a step during FETCH must be ignored.
        pushProg();
        base = nValid;
        startRun();
        chk("firstFetchEn", 32'(o_PmEn), 1);
        @(negedge i_Clk);
        i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        repeat (4) @(negedge i_Clk);
        i_Step = 1'b1;
        @(negedge i_Clk);
        i_Step = 1'b0;
        waitHalt(60);
        chk("run1Halted", 32'(o_Halted), 1);
        chk("run1Pc", 32'(o_PC), 3);
        chk("run1Count", 32'(nValid - base), 4);
        chk("run1SbEmpty", 32'(sb.size()), 0);

        // Restart from HALT.
        pushProg();
        base = nValid;
        startRun();
        chk("restartPc", 32'(o_PC), 0);
        chk("restartPmAddr", 32'(o_PmAddr), 0);
        chk("restartPmEn", 32'(o_PmEn), 1);
        waitHalt(60);
        chk("run2Pc", 32'(o_PC), 3);
        chk("run2Count", 32'(nValid - base), 4);
        chk("run2SbEmpty", 32'(sb.size()), 0);

        // Step mode: one instruction, then parked until each step.
        i_StepMode = 1'b1;
        sb.push_back(mk(LDI, 11'd5, 11'd0, 3));
        base = nValid;
        startRun();
        waitValid(base + 1, 10);
        busyCnt = 0;
        repeat (20) begin
            @(negedge i_Clk);
            if (o_Busy !== 1'b0 || o_Halted !== 1'b0) busyCnt++;
        end
        chk("pauseIdleCycles", 32'(busyCnt), 0);
        chk("pauseCount", 32'(nValid - base), 1);
        chk("pausePc", 32'(o_PC), 1);
        for (int k = 1; k < 4; k++) begin
            if (k == 1) sb.push_back(mk(ADDI, 11'd3, 11'd1, 3));
            if (k == 2) sb.push_back(mk(STO, 11'd10, 11'd2, 3));
            if (k == 3) sb.push_back(mk(HLT, 11'd0, 11'd3, 3));
            stepPulse();
            repeat (6) @(negedge i_Clk);
            chk("stepCount", 32'(nValid - base), 32'(k + 1));
        end
        chk("stepHalted", 32'(o_Halted), 1);
        stepPulse();
        repeat (5) @(negedge i_Clk);
        chk("haltIgnoresStep", 32'(nValid - base), 4);
        chk("haltStillHalted", 32'(o_Halted), 1);
        chk("stepSbEmpty", 32'(sb.size()), 0);
        i_StepMode = 1'b0;

        // PC wrap: LDI everywhere, 0x000 turned into HLT after its first use.
        for (int i = 0; i < 2048; i++) begin
            mem[i] = {LDI, 11'd1};
            sb.push_back(mk(LDI, 11'd1, 11'(i), 3 * (i + 1)));
        end
        sb.push_back(mk(HLT, 11'd0, 11'd0, 3 * 2049));
        base = nValid;
        startRun();
        waitValid(base + 1, 10);
        mem[0] = {HLT, 11'd0};
        waitHalt(7000);
        chk("wrapPc", 32'(o_PC), 0);
        chk("wrapCount", 32'(nValid - base), 2049);
        chk("wrapSbEmpty", 32'(sb.size()), 0);

        // Asynchronous reset during EXEC of ADDI.
        loadProg();
        pushProg();
        startRun();
        repeat (5) @(negedge i_Clk);
        chk("preRstValid", 32'(o_InstrValid), 1);
        chk("preRstOpcode", 32'(o_Opcode), 32'(ADDI));
        #1 i_Rst_n = 1'b0;
        #1;
        chk("asyncValidDrop", 32'(o_InstrValid), 0);
        chk("asyncPc", 32'(o_PC), 0);
        chk("asyncBusy", 32'(o_Busy), 0);
        sb.delete();
        base = nValid;
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
        repeat (8) @(negedge i_Clk);
        chk("postRstPc", 32'(o_PC), 0);
        chk("postRstBusy", 32'(o_Busy), 0);
        chk("postRstHalted", 32'(o_Halted), 0);
        chk("postRstNoSlot", 32'(nValid - base), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
